// File: rtl/seg_display_mux_if.sv
// Bus between a result-word source and the seven-segment display driver.
// The source (master) drives words/selection/mode; the driver (slave) drives the pins.
interface seg_display_mux_if #(
  parameter int NUM_DIGITS = 8,
  parameter int WORD_W     = 16,
  parameter int NUM_WORDS  = 5
);
  logic [NUM_WORDS*WORD_W-1:0] words_i;
  logic [3:0]                  sel_i;
  logic                        mode_i;
  logic [NUM_DIGITS-1:0]       disp_an_o;
  logic [6:0]                  disp_seg_o;
  logic                        disp_dp_o;

  modport master (
    output words_i, sel_i, mode_i,
    input  disp_an_o, disp_seg_o, disp_dp_o
  );

  modport slave (
    input  words_i, sel_i, mode_i,
    output disp_an_o, disp_seg_o, disp_dp_o
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver with per-frame word snapshot and auto-scroll.
// Optional macro SEG_LZ_BLANK_EN enables leading-zero suppression on the word digits.
module seg_display_mux #(
  parameter int NUM_DIGITS    = 8,
  parameter int WORD_W        = 16,
  parameter int NUM_WORDS     = 5,
  parameter int REFRESH_DIV   = 100000,
  parameter int SCROLL_FRAMES = 400
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  seg_display_mux_if.slave  bus
);
  localparam int NIB = WORD_W / 4;
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int PW  = $clog2(REFRESH_DIV);
  localparam int FW  = $clog2(SCROLL_FRAMES + 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX  = FW'(SCROLL_FRAMES - 1);
  localparam logic [3:0]    LAST_WORD  = 4'(NUM_WORDS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [PW-1:0]         presc_r;
  logic [DW-1:0]         digit_r;
  logic                  started_r;
  logic [FW-1:0]         fcnt_r;
  logic [3:0]            idx_r;
  logic [WORD_W-1:0]     word_r;
  logic                  valid_r;
  logic                  mode_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  logic                  tick_s;
  logic                  frame_start_s;
  logic [DW-1:0]         nd_s;
  logic [FW-1:0]         nfcnt_s;
  logic [3:0]            nidx_s;
  logic                  nmode_s;
  logic                  nvalid_s;
  logic [WORD_W-1:0]     word_mux_s;
  logic [WORD_W-1:0]     nword_s;
  logic [3:0]            nib_s;
  logic [6:0]            seg_s;

  assign tick_s = (presc_r == PRESC_MAX);
  // The very first tick after reset is a frame start, so digit 0 is shown first.
  assign frame_start_s = tick_s && (!started_r || (digit_r == LAST_DIGIT));
  assign nd_s = (!started_r || (digit_r == LAST_DIGIT)) ? '0 : digit_r + DW'(1);

  // Prescaler and digit scan counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_r   <= '0;
      digit_r   <= '0;
      started_r <= 1'b0;
    end else if (tick_s) begin
      presc_r   <= '0;
      digit_r   <= nd_s;
      started_r <= 1'b1;
    end else begin
      presc_r   <= presc_r + PW'(1);
    end
  end

  // Next snapshot: index selection, scroll stepping and the word mux.
  always_comb begin
    nidx_s     = idx_r;
    nfcnt_s    = fcnt_r;
    nmode_s    = mode_r;
    word_mux_s = '0;
    if (frame_start_s) begin
      nmode_s = bus.mode_i;
      if (bus.mode_i) begin
        if (fcnt_r == FRAME_MAX) begin
          nfcnt_s = '0;
          nidx_s  = (idx_r >= LAST_WORD) ? 4'd0 : idx_r + 4'd1;
        end else begin
          nfcnt_s = fcnt_r + FW'(1);
        end
      end else begin
        nidx_s  = bus.sel_i;
        nfcnt_s = '0;
      end
    end else begin
      nidx_s = idx_r;
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      word_mux_s = (nidx_s == 4'(k)) ? bus.words_i[k*WORD_W +: WORD_W] : word_mux_s;
    end
    nvalid_s = frame_start_s ? (nidx_s <= LAST_WORD) : valid_r;
    nword_s  = frame_start_s ? word_mux_s : word_r;
  end

  // Snapshot registers, updated only at frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_r  <= '0;
      idx_r   <= 4'd0;
      word_r  <= '0;
      valid_r <= 1'b1;
      mode_r  <= 1'b0;
    end else if (frame_start_s) begin
      fcnt_r  <= nfcnt_s;
      idx_r   <= nidx_s;
      word_r  <= nword_s;
      valid_r <= nvalid_s;
      mode_r  <= nmode_s;
    end
  end

  // Segment pattern for the digit about to be shown, from the post-tick snapshot.
  always_comb begin
    nib_s = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      nib_s = (nd_s == DW'(i)) ? nword_s[i*4 +: 4] : nib_s;
    end
    if (nd_s == LAST_DIGIT) begin
      seg_s = hex7(nidx_s);
    end else if (int'(nd_s) < NIB) begin
      if (!nvalid_s) begin
        seg_s = 7'h3F;
      end else begin
`ifdef SEG_LZ_BLANK_EN
        if ((nd_s != '0) && ((nword_s >> {nd_s, 2'b00}) == '0)) begin
          seg_s = 7'h7F;
        end else begin
          seg_s = hex7(nib_s);
        end
`else
        seg_s = hex7(nib_s);
`endif
      end
    end else begin
      seg_s = 7'h7F;
    end
  end

  // Output registers: anode, segments and dp all move together on each tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_r  <= '1;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else if (tick_s) begin
      an_r  <= ~(NUM_DIGITS'(1) << nd_s);
      seg_r <= seg_s;
      dp_r  <= !((nd_s == LAST_DIGIT) && nmode_s);
    end
  end

  assign bus.disp_an_o  = an_r;
  assign bus.disp_seg_o = seg_r;
  assign bus.disp_dp_o  = dp_r;
endmodule

// File: tb/tb_seg_display_mux.sv
// Directed, table-driven bench for seg_display_mux (5 digits, 16-bit words, 5 words).
module tb_seg_display_mux;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int errors = 0;

  seg_display_mux_if #(.NUM_DIGITS(ND), .WORD_W(16), .NUM_WORDS(5)) bus ();

  seg_display_mux #(
    .NUM_DIGITS(ND), .WORD_W(16), .NUM_WORDS(5), .REFRESH_DIV(4), .SCROLL_FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      sel;
    logic            mode;
    logic [15:0]     w4;
    logic [4:0][6:0] seg;
  } frame_t;

  frame_t tbl [18];

  function automatic frame_t mk(input logic [3:0] sel, input logic mode, input logic [15:0] w4,
                                input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                                input logic [6:0] d3, input logic [6:0] d4);
    frame_t f;
    f.sel = sel; f.mode = mode; f.w4 = w4;
    f.seg = {d4, d3, d2, d1, d0};
    return f;
  endfunction

  task automatic set_words(input logic [15:0] w4);
    bus.words_i = {w4, 16'h0000, 16'hFFFF, 16'h00A0, 16'h1234};
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [6:0] an, input logic [6:0] seg, input logic dp);
    checks++;
    if (bus.disp_an_o !== an[ND-1:0] || bus.disp_seg_o !== seg || bus.disp_dp_o !== dp) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, bus.disp_an_o, bus.disp_seg_o, bus.disp_dp_o, an[ND-1:0], seg, dp);
    end
  endtask

  task automatic chk_digit(input string name, input int d, input logic [6:0] seg, input logic mode);
    logic [6:0] an;
    an = ~(7'd1 << d);
    chk($sformatf("%s d%0d", name, d), an, seg, (d == ND - 1 && mode) ? 1'b0 : 1'b1);
  endtask

  initial begin
    logic [6:0] a0_d2, a0_d3, z_d1, z_d2, z_d3;
`ifdef SEG_LZ_BLANK_EN
    a0_d2 = 7'h7F; a0_d3 = 7'h7F; z_d1 = 7'h7F; z_d2 = 7'h7F; z_d3 = 7'h7F;
`else
    a0_d2 = 7'h40; a0_d3 = 7'h40; z_d1 = 7'h40; z_d2 = 7'h40; z_d3 = 7'h40;
`endif
    tbl[0]  = mk(4'd0, 1'b0, 16'hBEEF, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40);
    tbl[1]  = mk(4'd2, 1'b0, 16'hBEEF, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h24);
    tbl[2]  = mk(4'd7, 1'b0, 16'hBEEF, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h78);
    tbl[3]  = mk(4'd1, 1'b0, 16'hBEEF, 7'h40, 7'h08, a0_d2, a0_d3, 7'h79);
    tbl[4]  = mk(4'd3, 1'b0, 16'hBEEF, 7'h40, z_d1, z_d2, z_d3, 7'h30);
    tbl[5]  = mk(4'd0, 1'b0, 16'hBEEF, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40);
    tbl[6]  = mk(4'd9, 1'b1, 16'hBEEF, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40);
    tbl[7]  = mk(4'd9, 1'b1, 16'hBEEF, 7'h40, 7'h08, a0_d2, a0_d3, 7'h79);
    tbl[8]  = mk(4'd2, 1'b1, 16'hBEEF, 7'h40, 7'h08, a0_d2, a0_d3, 7'h79);
    tbl[9]  = mk(4'd2, 1'b1, 16'hBEEF, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h24);
    tbl[10] = mk(4'd2, 1'b1, 16'hBEEF, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h24);
    tbl[11] = mk(4'd2, 1'b1, 16'hBEEF, 7'h40, z_d1, z_d2, z_d3, 7'h30);
    tbl[12] = mk(4'd2, 1'b1, 16'hBEEF, 7'h40, z_d1, z_d2, z_d3, 7'h30);
    tbl[13] = mk(4'd2, 1'b1, 16'hBEEF, 7'h0E, 7'h06, 7'h06, 7'h03, 7'h19);
    tbl[14] = mk(4'd2, 1'b1, 16'hBEEF, 7'h0E, 7'h06, 7'h06, 7'h03, 7'h19);
    tbl[15] = mk(4'd2, 1'b1, 16'hBEEF, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40);
    tbl[16] = mk(4'd4, 1'b0, 16'hBEEF, 7'h0E, 7'h06, 7'h06, 7'h03, 7'h19);
    tbl[17] = mk(4'd4, 1'b0, 16'h5678, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19);

    set_words(tbl[0].w4);
    bus.sel_i  = tbl[0].sel;
    bus.mode_i = tbl[0].mode;
    step(3);
    chk("in_reset", 7'h1F, 7'h7F, 1'b1);
    rst_ni = 1'b1;
    step(3);
    chk("pre_first_tick", 7'h1F, 7'h7F, 1'b1);
    step(1);

    // New selection/mode/word4 is driven mid-frame and must only appear next frame.
    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < ND; d++) begin
        chk_digit($sformatf("frame%0d", i), d, tbl[i].seg[d], tbl[i].mode);
        if (d == 2 && i < 17) begin
          bus.sel_i  = tbl[i+1].sel;
          bus.mode_i = tbl[i+1].mode;
          set_words(tbl[i+1].w4);
        end
        step(4);
      end
    end

    // Asynchronous reset in the middle of a digit slot.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset", 7'h1F, 7'h7F, 1'b1);
    bus.sel_i  = 4'd3;
    bus.mode_i = 1'b1;
    set_words(16'hBEEF);
    @(negedge clk);
    rst_ni = 1'b1;
    step(3);
    chk("post_reset_pre_tick", 7'h1F, 7'h7F, 1'b1);
    step(1);
    for (int d = 0; d < ND; d++) begin
      chk_digit("after_reset", d, tbl[0].seg[d], 1'b1);
      step(4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
